dtree_seq_eval: RTL



---
 rtl/dtree_pkg.sv | 95 +++++++++
 rtl/dtree_seq_eval_if.sv | 39 +++
 rtl/dtree_node_mem.sv | 32 +++
 rtl/dtree_seq_eval.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree classifier.
// Holds field-width helpers, node-word field offsets, the walk FSM state
// type and node_pack(), which builds node words for benches and generators.
//
// Node word layout, MSB to LSB:
//   leaf(1) | feat_idx(FIDX_W) | prec(PREC_W) | thresh(FEAT_W) | t_ptr(NODE_W) | f_ptr(NODE_W)
package dtree_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned fidx_w(input int unsigned n_feat);
    return (n_feat < 2) ? 1 : $clog2(n_feat);
  endfunction

  function automatic int unsigned prec_w(input int unsigned feat_w);
    return $clog2(feat_w + 1);
  endfunction

  function automatic int unsigned node_w(input int unsigned n_nodes);
    return (n_nodes < 2) ? 1 : $clog2(n_nodes);
  endfunction

  function automatic int unsigned node_dw(input int unsigned n_feat, input int unsigned feat_w,
                                          input int unsigned nw);
    return 1 + fidx_w(n_feat) + prec_w(feat_w) + feat_w + 2 * nw;
  endfunction

  // Field offsets (LSB position of each field in the node word)
  function automatic int unsigned off_fptr();
    return 0;
  endfunction

  function automatic int unsigned off_tptr(input int unsigned nw);
    return nw;
  endfunction

  function automatic int unsigned off_thresh(input int unsigned nw);
    return 2 * nw;
  endfunction

  function automatic int unsigned off_prec(input int unsigned feat_w, input int unsigned nw);
    return 2 * nw + feat_w;
  endfunction

  function automatic int unsigned off_fidx(input int unsigned feat_w, input int unsigned nw);
    return off_prec(feat_w, nw) + prec_w(feat_w);
  endfunction

  function automatic int unsigned off_leaf(input int unsigned n_feat, input int unsigned feat_w,
                                           input int unsigned nw);
    return off_fidx(feat_w, nw) + fidx_w(n_feat);
  endfunction

  // Offsets for the default build (N_FEAT=5, FEAT_W=8, N_NODES=16)
  localparam int unsigned DEF_NODE_W     = 4;
  localparam int unsigned DEF_OFF_FPTR   = 0;
  localparam int unsigned DEF_OFF_TPTR   = 4;
  localparam int unsigned DEF_OFF_THRESH = 8;
  localparam int unsigned DEF_OFF_PREC   = 16;
  localparam int unsigned DEF_OFF_FIDX   = 20;
  localparam int unsigned DEF_OFF_LEAF   = 23;
  localparam int unsigned DEF_NODE_DW    = 24;

  function automatic logic [63:0] field_mask(input int unsigned bits);
    return (64'(1) << bits) - 64'(1);
  endfunction

  // Packs a node word right-aligned in 64 bits; callers slice to NODE_DW.
  function automatic logic [63:0] node_pack(
    input int unsigned n_feat, input int unsigned feat_w, input int unsigned nw,
    input int unsigned leaf, input int unsigned fidx, input int unsigned prec,
    input int unsigned thresh, input int unsigned tptr, input int unsigned fptr);
    logic [63:0] w;
    int unsigned pos;
    w   = '0;
    pos = 0;
    w |= (64'(fptr) & field_mask(nw)) << pos;
    pos += nw;
    w |= (64'(tptr) & field_mask(nw)) << pos;
    pos += nw;
    w |= (64'(thresh) & field_mask(feat_w)) << pos;
    pos += feat_w;
    w |= (64'(prec) & field_mask(prec_w(feat_w))) << pos;
    pos += prec_w(feat_w);
    w |= (64'(fidx) & field_mask(fidx_w(n_feat))) << pos;
    pos += fidx_w(n_feat);
    w |= (64'(leaf) & 64'(1)) << pos;
    return w;
  endfunction

endpackage

// File: rtl/dtree_seq_eval_if.sv
// Handshake/config bundle for dtree_seq_eval.
//   in_valid/in_ready/in_feat     : feature vector input (feature i at [i*FEAT_W +: FEAT_W])
//   out_valid/out_ready           : result handshake
//   out_class/out_err             : class label and walk-failure flag
//   cfg_we/cfg_addr/cfg_data      : node-table write port
//   cfg_busy                      : high while a classification is in progress
// master = producer/consumer side, slave = classifier.
interface dtree_seq_eval_if
  import dtree_pkg::*;
#(
  parameter int unsigned N_FEAT  = 5,
  parameter int unsigned FEAT_W  = 8,
  parameter int unsigned CLASS_W = 5,
  parameter int unsigned N_NODES = 16,
  parameter int unsigned NODE_W  = node_w(N_NODES),
  parameter int unsigned NODE_DW = node_dw(N_FEAT, FEAT_W, NODE_W)
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     cfg_we;
  logic [NODE_W-1:0]        cfg_addr;
  logic [NODE_DW-1:0]       cfg_data;
  logic                     cfg_busy;

  modport master (
    output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_class, out_err, cfg_busy
  );

  modport slave (
    input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_class, out_err, cfg_busy
  );
endinterface

// File: rtl/dtree_node_mem.sv
// Node table: N_NODES x NODE_DW register file.
//   clk, rst  : clock, synchronous active-high clear of every entry
//   we_i      : write strobe; waddr_i/wdata_i written on the clock edge
//   raddr_i   : combinational read address; rdata_o = node[raddr_i]
// Addresses at or beyond N_NODES are ignored on write and read as zero.
module dtree_node_mem #(
  parameter int unsigned N_NODES = 16,
  parameter int unsigned NODE_W  = 4,
  parameter int unsigned NODE_DW = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [NODE_W-1:0]  waddr_i,
  input  logic [NODE_DW-1:0] wdata_i,
  input  logic [NODE_W-1:0]  raddr_i,
  output logic [NODE_DW-1:0] rdata_o
);
  localparam int unsigned IDX_W = (N_NODES < 2) ? 1 : $clog2(N_NODES);

  logic [NODE_DW-1:0] mem_q [N_NODES];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we_i && (32'(waddr_i) < N_NODES)) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < N_NODES) ? mem_q[raddr_i[IDX_W-1:0]] : '0;
endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree classifier: one node visited per clock from a
// run-time-writable node table.
//   clk, rst : clock, synchronous active-high reset (also clears the table)
//   bus      : dtree_seq_eval_if slave (feature input, result output, config)
// Accept in IDLE, walk from node 0 until a leaf or an error, present the
// result in DONE until out_ready.
module dtree_seq_eval
  import dtree_pkg::*;
#(
  parameter int unsigned N_FEAT    = 5,
  parameter int unsigned FEAT_W    = 8,
  parameter int unsigned CLASS_W   = 5,
  parameter int unsigned N_NODES   = 16,
  parameter int unsigned MAX_DEPTH = 12,
  parameter int unsigned NODE_W    = node_w(N_NODES)
) (
  input logic             clk,
  input logic             rst,
  dtree_seq_eval_if.slave bus
);
  localparam int unsigned FIDX_W   = fidx_w(N_FEAT);
  localparam int unsigned PREC_W   = prec_w(FEAT_W);
  localparam int unsigned NODE_DW  = node_dw(N_FEAT, FEAT_W, NODE_W);
  localparam int unsigned STEP_W   = (MAX_DEPTH < 2) ? 1 : $clog2(MAX_DEPTH);
  localparam int unsigned OFF_FPTR = off_fptr();
  localparam int unsigned OFF_TPTR = off_tptr(NODE_W);
  localparam int unsigned OFF_THR  = off_thresh(NODE_W);
  localparam int unsigned OFF_PREC = off_prec(FEAT_W, NODE_W);
  localparam int unsigned OFF_FIDX = off_fidx(FEAT_W, NODE_W);
  localparam int unsigned OFF_LEAF = off_leaf(N_FEAT, FEAT_W, NODE_W);
  localparam logic [FEAT_W-1:0] ONES = '1;

  state_e                   state_q, state_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [NODE_W-1:0]        ptr_q, ptr_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic                     err_q, err_d;

  logic [NODE_DW-1:0] node;
  logic               n_leaf;
  logic [FIDX_W-1:0]  n_fidx;
  logic [PREC_W-1:0]  n_prec;
  logic [FEAT_W-1:0]  n_thr;
  logic [NODE_W-1:0]  n_tptr, n_fptr;

  logic [FEAT_W-1:0]  feat_sel;
  logic [PREC_W-1:0]  prec_eff, shamt;
  logic [FEAT_W-1:0]  feat_top, thr_low;
  logic               cond, fidx_bad, ptr_bad, last_step;
  logic [NODE_W-1:0]  next_ptr;

  dtree_node_mem #(
    .N_NODES (N_NODES),
    .NODE_W  (NODE_W),
    .NODE_DW (NODE_DW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.cfg_we && (state_q == IDLE)),
    .waddr_i (bus.cfg_addr),
    .wdata_i (bus.cfg_data),
    .raddr_i (ptr_q),
    .rdata_o (node)
  );

  assign n_leaf = node[OFF_LEAF];
  assign n_fidx = node[OFF_FIDX +: FIDX_W];
  assign n_prec = node[OFF_PREC +: PREC_W];
  assign n_thr  = node[OFF_THR  +: FEAT_W];
  assign n_tptr = node[OFF_TPTR +: NODE_W];
  assign n_fptr = node[OFF_FPTR +: NODE_W];

  // Out-of-range feature index selects zero; fidx_bad flags it separately.
  always_comb begin
    feat_sel = '0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (32'(n_fidx) == i) feat_sel = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  // Compare the top prec bits of the feature against the low prec bits of
  // the threshold. Both sides are right-aligned, so prec=0 gives 0 <= 0.
  assign prec_eff  = (32'(n_prec) > FEAT_W) ? PREC_W'(FEAT_W) : n_prec;
  assign shamt     = PREC_W'(FEAT_W) - prec_eff;
  assign feat_top  = feat_sel >> shamt;
  assign thr_low   = n_thr & ~(ONES << prec_eff);
  assign cond      = (feat_top <= thr_low);
  assign next_ptr  = cond ? n_tptr : n_fptr;
  assign fidx_bad  = (32'(n_fidx) >= N_FEAT);
  assign ptr_bad   = (32'(next_ptr) >= N_NODES);
  assign last_step = (32'(step_q) == MAX_DEPTH - 1);

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    ptr_d   = ptr_q;
    step_d  = step_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          feat_d  = bus.in_feat;
          ptr_d   = '0;
          step_d  = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (n_leaf) begin
          class_d = n_thr[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (fidx_bad || ptr_bad || last_step) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d  = next_ptr;
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      feat_q  <= '0;
      ptr_q   <= '0;
      step_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Result fields are gated so they read zero whenever no result is offered.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_class = (state_q == DONE) ? class_q : '0;
  assign bus.out_err   = (state_q == DONE) ? err_q : 1'b0;
  assign bus.cfg_busy  = (state_q != IDLE);
endmodule
